// File: rtl/gpu_command_buffer.sv
// Command buffer feeding the GPU control unit: packs host words into 4-word
// commands (opcode + 3 operands) and presents the head command word by word.
module gpu_command_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic              avs_waitrequest,
  input  logic              read,
  input  logic              busy_reset,
  output logic              busy,
  output logic [DATA_W-1:0] cmd_word,
  output logic [1:0]        cmd_index,
  output logic              cmd_error
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int ADDR_W = PTR_W + 2;

  logic [DATA_W-1:0] mem [4*DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_base;
  logic [1:0]        wr_sub;
  logic [1:0]        rd_sub;
  logic [CNT_W-1:0]  cmd_count;

  logic wr_accept;
  logic wr_done;
  logic retire;
  logic rd_step;
  logic err_evt;

  // Host handshake: a word transfers on any cycle with avs_write=1 and
  // avs_waitrequest=0. Waitrequest comes only from registers, so the host
  // never sees a combinational path from its own strobe or from busy_reset.
  assign avs_waitrequest = (wr_sub == 2'd0) && (cmd_count == CNT_W'(DEPTH));
  assign wr_accept       = avs_write && !avs_waitrequest;
  assign wr_done         = wr_accept && (wr_sub == 2'd3);

  assign busy      = (cmd_count != '0);
  assign cmd_index = rd_sub;
  assign cmd_word  = busy ? mem[ADDR_W'({rd_base, rd_sub})] : '0;

  // busy_reset has priority: a read in the same cycle is dropped silently.
  assign retire  = busy_reset && busy;
  assign rd_step = read && !busy_reset && busy && (rd_sub != 2'd3);
  assign err_evt = (busy_reset && !busy) ||
                   (read && !busy_reset && (!busy || (rd_sub == 2'd3)));

  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem[ADDR_W'({wr_ptr, wr_sub})] <= avs_writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      wr_sub    <= 2'd0;
      rd_base   <= '0;
      rd_sub    <= 2'd0;
      cmd_count <= '0;
      cmd_error <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_sub <= wr_sub + 2'd1;
        if (wr_sub == 2'd3) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
      end
      if (retire) begin
        rd_base <= rd_base + PTR_W'(1);
        rd_sub  <= 2'd0;
      end else if (rd_step) begin
        rd_sub <= rd_sub + 2'd1;
      end
      case ({wr_done, retire})
        2'b10:   cmd_count <= cmd_count + CNT_W'(1);
        2'b01:   cmd_count <= cmd_count - CNT_W'(1);
        default: cmd_count <= cmd_count;
      endcase
      if (err_evt) begin
        cmd_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gpu_command_buffer.sv
// Bench for gpu_command_buffer: directed scenarios plus random traffic,
// all scored against a word-queue model of the buffer.
module tb_gpu_command_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              reset;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic              avs_waitrequest;
  logic              read;
  logic              busy_reset;
  logic              busy;
  logic [DATA_W-1:0] cmd_word;
  logic [1:0]        cmd_index;
  logic              cmd_error;

  int tests_run;
  int tests_failed;

  // Model: complete commands stored as a flat word queue, 4 words each.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] part_q[$];
  int                head_idx;
  logic              exp_err;

  gpu_command_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_waitrequest (avs_waitrequest),
    .read            (read),
    .busy_reset      (busy_reset),
    .busy            (busy),
    .cmd_word        (cmd_word),
    .cmd_index       (cmd_index),
    .cmd_error       (cmd_error)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_busy();
    return exp_q.size() != 0;
  endfunction

  function automatic logic m_waitreq();
    return (part_q.size() == 0) && (exp_q.size() == 4 * DEPTH);
  endfunction

  task automatic check_outputs();
    check_eq("busy", DATA_W'(busy), DATA_W'(m_busy()));
    check_eq("waitrequest", DATA_W'(avs_waitrequest), DATA_W'(m_waitreq()));
    check_eq("cmd_word", cmd_word, m_busy() ? exp_q[head_idx] : '0);
    check_eq("cmd_index", DATA_W'(cmd_index), DATA_W'(head_idx));
    check_eq("cmd_error", DATA_W'(cmd_error), DATA_W'(exp_err));
  endtask

  // ---------------- drivers ----------------
  task automatic step(input logic w, input logic [DATA_W-1:0] d,
                      input logic r, input logic br);
    logic accept;
    @(negedge clk);
    reset         = 1'b0;
    avs_write     = w;
    avs_writedata = d;
    read          = r;
    busy_reset    = br;
    accept = w && !m_waitreq();
    if (br) begin
      if (m_busy()) begin
        repeat (4) void'(exp_q.pop_front());
        head_idx = 0;
      end else begin
        exp_err = 1'b1;
      end
    end else if (r) begin
      if (!m_busy() || head_idx == 3) exp_err = 1'b1;
      else head_idx++;
    end
    if (accept) begin
      part_q.push_back(d);
      if (part_q.size() == 4) begin
        foreach (part_q[i]) exp_q.push_back(part_q[i]);
        part_q.delete();
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input logic w);
    @(negedge clk);
    reset         = 1'b1;
    avs_write     = w;
    avs_writedata = $urandom;
    read          = 1'b0;
    busy_reset    = 1'b0;
    exp_q.delete();
    part_q.delete();
    head_idx = 0;
    exp_err  = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic write_word(input logic [DATA_W-1:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    avs_write     = 1'b0;
    avs_writedata = '0;
    read          = 1'b0;
    busy_reset    = 1'b0;
    head_idx      = 0;
    exp_err       = 1'b0;
    repeat (2) @(posedge clk);
    do_reset(1'b0);

    // Basic command: opcode then three operands, read back, retire.
    write_word(32'h01); write_word(32'h0A); write_word(32'h0B);
    write_word(32'h0C);
    check_eq("dir_busy_after_4th", DATA_W'(busy), 32'd1);
    check_eq("dir_opcode", cmd_word, 32'h01);
    step(1'b0, '0, 1'b1, 1'b0);
    check_eq("dir_op1", cmd_word, 32'h0A);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_eq("dir_op3", cmd_word, 32'h0C);
    check_eq("dir_idx3", DATA_W'(cmd_index), 32'd3);
    step(1'b0, '0, 1'b0, 1'b1);
    check_eq("dir_empty_word", cmd_word, 32'h0);

    // Fill all slots, hold the 17th word, free a slot.
    for (int i = 0; i < 4 * DEPTH; i++) write_word(32'h100 + i);
    check_eq("dir_full_waitreq", DATA_W'(avs_waitrequest), 32'd1);
    write_word(32'h1FF);
    step(1'b1, 32'h1FF, 1'b0, 1'b1);
    check_eq("dir_freed_waitreq", DATA_W'(avs_waitrequest), 32'd0);
    write_word(32'h1FF);
    repeat (2 * DEPTH) step(1'b0, '0, 1'b0, 1'b1);
    do_reset(1'b0);

    // Completing write coincides with retire of the pending command.
    for (int i = 0; i < 4; i++) write_word(32'h200 + i);
    write_word(32'h300); write_word(32'h301); write_word(32'h302);
    step(1'b1, 32'h303, 1'b0, 1'b1);
    check_eq("dir_overlap_busy", DATA_W'(busy), 32'd1);
    check_eq("dir_overlap_head", cmd_word, 32'h300);

    // Early retire discards unread operands without error.
    for (int i = 0; i < 4; i++) write_word(32'h400 + i);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    check_eq("dir_early_head", cmd_word, 32'h400);
    check_eq("dir_early_err", DATA_W'(cmd_error), 32'd0);
    step(1'b0, '0, 1'b1, 1'b1);  // read+retire together: no error
    check_eq("dir_rdbr_err", DATA_W'(cmd_error), 32'd0);

    // Protocol errors: read when empty, read past idx 3, retire when empty.
    step(1'b0, '0, 1'b1, 1'b0);
    check_eq("dir_err_read_empty", DATA_W'(cmd_error), 32'd1);
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) write_word(32'h500 + i);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    check_eq("dir_err_overread", DATA_W'(cmd_error), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    idle();
    do_reset(1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    check_eq("dir_err_retire_empty", DATA_W'(cmd_error), 32'd1);

    // Reset mid-stream after 10 words, with a write in the reset cycle.
    for (int i = 0; i < 10; i++) write_word(32'h600 + i);
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) write_word(32'h700 + i);
    check_eq("dir_post_reset_op", cmd_word, 32'h700);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        step($urandom_range(0, 99) < 60, $urandom,
             $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 12);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
